// File: rtl/mem_pkg.sv
// Shared types and constants for the fixed-latency memory block.
package mem_pkg;

  localparam int DEFAULT_WORD_SIZE = 16;
  localparam int CNT_W             = 4;
  localparam logic [15:0] ERR_READ = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/latency_mem_if.sv
// Control bundle between the latency_mem FSM (master) and its latency counter (slave).
interface latency_mem_if;
  import mem_pkg::*;

  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             dec;
  logic             zero;

  modport master (output load, load_val, dec, input zero);
  modport slave  (input load, load_val, dec, output zero);
endinterface

// File: rtl/latency_counter.sv
// Down-counter that measures the wait between request accept and response.
module latency_counter
  import mem_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  latency_mem_if.slave ctl
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ctl.load) begin
      cnt_d = ctl.load_val;
    end else if (ctl.dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ctl.zero = (cnt_q == '0);
endmodule

// File: rtl/latency_mem.sv
// Word memory answering each request a fixed LATENCY cycles after accept, on a shared tristate bus.
// Define LATENCY_MEM_BOUNDS_CHECK_EN to add addr_err and reject addresses above the array depth.
module latency_mem
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 busy,
`ifdef LATENCY_MEM_BOUNDS_CHECK_EN
  output logic                 addr_err,
`endif
  output state_e               dbg_state
);
  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic                 addr_hi;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] rd_word;
  logic [WORD_SIZE-1:0] mem_q [DEPTH];

  latency_mem_if cnt_if ();

  latency_counter u_cnt (
    .clk (clk),
    .rst (reset),
    .ctl (cnt_if)
  );

`ifdef LATENCY_MEM_BOUNDS_CHECK_EN
  assign addr_hi  = |address[WORD_SIZE-1:ADDR_BITS];
  assign addr_err = inputReady & err_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];
  assign addr_hi        = 1'b0;
`endif

  // Every accepted request passes through WAIT, so LATENCY=1 still spends one cycle there.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    idx_d           = idx_q;
    wdata_d         = wdata_q;
    err_d           = err_q;
    mem_we          = 1'b0;
    cnt_if.load     = 1'b0;
    cnt_if.load_val = LOAD_VAL;
    cnt_if.dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (readM || writeM) begin
          state_d     = WAIT;
          op_d        = writeM ? OP_WR : OP_RD;
          idx_d       = address[ADDR_BITS-1:0];
          wdata_d     = data;
          err_d       = addr_hi;
          cnt_if.load = 1'b1;
        end
      end
      WAIT: begin
        cnt_if.dec = 1'b1;
        if (cnt_if.zero) begin
          state_d = RESP;
          mem_we  = (op_q == OP_WR) && !err_q && !reset;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign rd_word    = err_q ? WORD_SIZE'(ERR_READ) : mem_q[idx_q];
  assign inputReady = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;
  assign data       = (inputReady && (op_q == OP_RD)) ? rd_word : 'z;
endmodule

// File: tb/tb_latency_mem.sv
// Bench for latency_mem: timeline model of the LATENCY=2 instance plus directed LATENCY=1 checks.
module tb_latency_mem;
  import mem_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        readM, writeM;
  logic [15:0] address;
  wire  [15:0] data;
  logic        inputReady, busy;
  state_e      dbg_state;
  logic        tb_oe;
  logic [15:0] tb_dq;

  logic        rd1, wr1;
  logic [15:0] addr1;
  wire  [15:0] data1;
  logic        rdy1, busy1;
  state_e      dbg_state1;
  logic        tb1_oe;
  logic [15:0] tb1_dq;

`ifdef LATENCY_MEM_BOUNDS_CHECK_EN
  logic addr_err, addr_err1;
`endif

  int checks = 0;
  int errors = 0;

  // Model of the LATENCY=2 instance: one operation in flight, described by its accept edge.
  int          cyc      = 0;
  logic        m_active = 1'b0;
  int          m_acc    = 0;
  logic        m_wr     = 1'b0;
  logic [9:0]  m_idx    = '0;
  logic [15:0] m_wdata  = '0;
  logic        m_err    = 1'b0;
  logic [15:0] m_mem [1024];

  logic        e_rdy, e_busy;
  logic [15:0] e_data;

  localparam logic [15:0] T_ADDR [3] = '{16'h03FF, 16'h0000, 16'h0200};
  localparam logic [15:0] T_DATA [3] = '{16'hA5A5, 16'h0001, 16'h8000};

  assign data  = tb_oe ? tb_dq : 'z;
  assign tb_oe = !(m_active && !m_wr && (cyc == m_acc + LAT));
  assign data1 = tb1_oe ? tb1_dq : 'z;

  latency_mem #(.WORD_SIZE(16), .ADDR_BITS(10), .LATENCY(LAT)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .readM      (readM),
    .writeM     (writeM),
    .address    (address),
    .data       (data),
    .inputReady (inputReady),
    .busy       (busy),
`ifdef LATENCY_MEM_BOUNDS_CHECK_EN
    .addr_err   (addr_err),
`endif
    .dbg_state  (dbg_state)
  );

  latency_mem #(.WORD_SIZE(16), .ADDR_BITS(10), .LATENCY(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .readM      (rd1),
    .writeM     (wr1),
    .address    (addr1),
    .data       (data1),
    .inputReady (rdy1),
    .busy       (busy1),
`ifdef LATENCY_MEM_BOUNDS_CHECK_EN
    .addr_err   (addr_err1),
`endif
    .dbg_state  (dbg_state1)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model timeline: accept at edge A, write lands at edge A+LAT, RESP exit at A+LAT+1 ignores requests.
  initial begin
    for (int i = 0; i < 1024; i++) m_mem[i] = '0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_active = 1'b0;
        cyc      = 0;
      end else begin
        cyc++;
        if (m_active && (cyc == m_acc + LAT)) begin
          if (m_wr && !m_err) m_mem[m_idx] = m_wdata;
        end else if (m_active && (cyc == m_acc + LAT + 1)) begin
          m_active = 1'b0;
        end else if (!m_active && (readM || writeM)) begin
          m_active = 1'b1;
          m_acc    = cyc;
          m_wr     = writeM;
          m_idx    = address[9:0];
          m_wdata  = tb_dq;
`ifdef LATENCY_MEM_BOUNDS_CHECK_EN
          m_err    = |address[15:10];
`else
          m_err    = 1'b0;
`endif
        end
      end
    end
  end

  // Per-cycle comparison of the LATENCY=2 instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      e_rdy  = m_active && (cyc == m_acc + LAT);
      e_busy = m_active;
      if (e_rdy && !m_wr) e_data = m_err ? 16'hFFFF : m_mem[m_idx];
      else                e_data = tb_dq;
      chk("cyc_inputReady", {31'b0, inputReady}, {31'b0, e_rdy});
      chk("cyc_busy", {31'b0, busy}, {31'b0, e_busy});
      chk("cyc_data", {16'b0, data}, {16'b0, e_data});
`ifdef LATENCY_MEM_BOUNDS_CHECK_EN
      chk("cyc_addr_err", {31'b0, addr_err}, {31'b0, e_rdy && m_err});
`endif
    end
  end

  // Driver: raise the request, hold until the model's response cycle, scramble inputs after accept.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, output int rel, output logic [15:0] rdata);
    int start;
    start  = cyc;
    rel    = -1;
    rdata  = '0;
    readM  = rd;
    writeM = wr;
    address = a;
    tb_dq  = wd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (m_active && (cyc == m_acc)) begin
        address = ~a;
        tb_dq   = 16'h0000;
      end
      if (inputReady && (rel < 0)) rel = cyc - start;
      if (m_active && (cyc == m_acc + LAT)) begin
        rdata = data;
        break;
      end
    end
    readM   = 1'b0;
    writeM  = 1'b0;
    address = '0;
    tb_dq   = '0;
  endtask

  int          rel;
  logic [15:0] rd;
  int          seen;
  logic [8:0]  rdy_pat, busy_pat;

  initial begin
    reset = 1'b1; readM = 1'b0; writeM = 1'b0; address = '0; tb_dq = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; tb1_oe = 1'b0; tb1_dq = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_inputReady", {31'b0, inputReady}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    reset = 1'b0;

    // First request after reset is accepted at edge 1 and answered after edge 3.
    do_req(1'b0, 1'b1, 16'h0010, 16'h1234, rel, rd);
    chk("w0010_ready_cycle", rel, 32'd3);
    // Back-to-back: the RESP-exit edge ignores the request, so the answer comes one cycle later.
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, rel, rd);
    chk("r0010_ready_cycle", rel, 32'd4);
    chk("r0010_data", {16'b0, rd}, 32'h1234);

    do_req(1'b1, 1'b0, 16'h0410, 16'h0000, rel, rd);
`ifdef LATENCY_MEM_BOUNDS_CHECK_EN
    chk("r0410_err_data", {16'b0, rd}, 32'hFFFF);
`else
    chk("r0410_alias_data", {16'b0, rd}, 32'h1234);
`endif

    // Read+write together is a write: the bench holds 0 on the bus, so a read response would show.
    do_req(1'b1, 1'b1, 16'h0020, 16'hBEEF, rel, rd);
    chk("rw0020_bus_not_driven", {16'b0, rd}, 32'h0000);
    do_req(1'b1, 1'b0, 16'h0020, 16'h0000, rel, rd);
    chk("r0020_data", {16'b0, rd}, 32'hBEEF);

    for (int i = 0; i < 3; i++) do_req(1'b0, 1'b1, T_ADDR[i], T_DATA[i], rel, rd);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 1'b0, T_ADDR[i], 16'h0000, rel, rd);
      chk("table_read", {16'b0, rd}, {16'b0, T_DATA[i]});
    end

    do_req(1'b0, 1'b1, 16'h0410, 16'hDEAD, rel, rd);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0000, rel, rd);
`ifdef LATENCY_MEM_BOUNDS_CHECK_EN
    chk("r0010_after_oob_write", {16'b0, rd}, 32'h1234);
`else
    chk("r0010_after_alias_write", {16'b0, rd}, 32'hDEAD);
`endif

    // Reset during WAIT aborts the write and clears busy without a clock edge.
    do_req(1'b0, 1'b1, 16'h0030, 16'h7777, rel, rd);
    @(negedge clk); #1;
    writeM = 1'b1; address = 16'h0030; tb_dq = 16'h5555;
    @(negedge clk); #1;
    writeM = 1'b0; address = '0; tb_dq = '0;
    chk("abort_busy_in_wait", {31'b0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy_async", {31'b0, busy}, 32'd0);
    chk("abort_inputReady", {31'b0, inputReady}, 32'd0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    reset = 1'b0;
    do_req(1'b1, 1'b0, 16'h0030, 16'h0000, rel, rd);
    chk("r0030_ready_cycle", rel, 32'd3);
    chk("r0030_kept_value", {16'b0, rd}, 32'h7777);

    // LATENCY=1 instance: one write, then readM held high continuously.
    @(negedge clk); #1;
    wr1 = 1'b1; addr1 = 16'h0005; tb1_dq = 16'h0A0A; tb1_oe = 1'b1;
    seen = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (rdy1) begin
        seen = i;
        break;
      end
    end
    chk("l1_write_ready_cycle", seen, 32'd1);
    wr1 = 1'b0; tb1_oe = 1'b0; rd1 = 1'b1;
    rdy_pat = '0; busy_pat = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      rdy_pat[i]  = rdy1;
      busy_pat[i] = busy1;
      if (rdy1) chk("l1_read_data", {16'b0, data1}, 32'h0A0A);
    end
    rd1 = 1'b0;
    chk("l1_ready_pattern", {23'b0, rdy_pat}, {23'b0, 9'b100100100});
    chk("l1_busy_pattern", {23'b0, busy_pat}, {23'b0, 9'b110110110});

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
